// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the shared register-file write port (A=ALU, B=load, C=link).
// Registers the winning grant, mux select, address and data for a single clean write per cycle.
module wb_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic [2:0]            req,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [ADDR_WIDTH-1:0] addr_c,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [DATA_WIDTH-1:0] data_c,
  output logic [2:0]            gnt,
  output logic [1:0]            sel,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  typedef enum logic [1:0] {
    PRI_A = 2'd0,
    PRI_B = 2'd1,
    PRI_C = 2'd2
  } pri_e;

  pri_e                  state;
  logic [2:0]            elig_c;
  logic                  win_vld_c;
  logic [1:0]            win_c;
  logic [ADDR_WIDTH-1:0] win_addr_c;
  logic [DATA_WIDTH-1:0] win_data_c;

  // The requester granted this cycle is masked so its held request is not granted twice.
  always_comb begin
    elig_c    = req & ~gnt;
    win_vld_c = !stall && (elig_c != 3'b000);
    win_c     = 2'd0;
    case (state)
      PRI_B: begin
        if (elig_c[1])      win_c = 2'd1;
        else if (elig_c[2]) win_c = 2'd2;
        else                win_c = 2'd0;
      end
      PRI_C: begin
        if (elig_c[2])      win_c = 2'd2;
        else if (elig_c[0]) win_c = 2'd0;
        else                win_c = 2'd1;
      end
      default: begin
        if (elig_c[0])      win_c = 2'd0;
        else if (elig_c[1]) win_c = 2'd1;
        else                win_c = 2'd2;
      end
    endcase
  end

  // Winner's address/data mux.
  always_comb begin
    win_addr_c = addr_a;
    win_data_c = data_a;
    case (win_c)
      2'd1: begin
        win_addr_c = addr_b;
        win_data_c = data_b;
      end
      2'd2: begin
        win_addr_c = addr_c;
        win_data_c = data_c;
      end
      default: begin
        win_addr_c = addr_a;
        win_data_c = data_a;
      end
    endcase
  end

  // Pointer FSM plus registered write-port outputs; sel/addr/data hold when nothing is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PRI_A;
      gnt     <= 3'b000;
      sel     <= 2'b00;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (win_vld_c) begin
      gnt     <= 3'b001 << win_c;
      sel     <= win_c;
      wr_en   <= (win_addr_c != '0);
      wr_addr <= win_addr_c;
      wr_data <= win_data_c;
      case (win_c)
        2'd0:    state <= PRI_B;
        2'd1:    state <= PRI_C;
        default: state <= PRI_A;
      endcase
    end else begin
      gnt   <= 3'b000;
      wr_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed vectors push expected grants,
// an independent monitor pops and compares whenever a grant or write appears.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [2:0]  req;
  logic [4:0]  addr_a, addr_b, addr_c;
  logic [31:0] data_a, data_b, data_c;
  logic [2:0]  gnt;
  logic [1:0]  sel;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  typedef struct packed {
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [31:0] DA = 32'hA000_0001;
  localparam logic [31:0] DB = 32'hB000_0002;
  localparam logic [31:0] DC = 32'hC000_0003;

  wb_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .req(req),
    .addr_a(addr_a), .addr_b(addr_b), .addr_c(addr_c),
    .data_a(data_a), .data_b(data_b), .data_c(data_c),
    .gnt(gnt), .sel(sel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [2:0] g, input logic [1:0] s, input logic e,
                      input logic [4:0] a, input logic [31:0] d);
    exp_t x;
    x.gnt = g; x.sel = s; x.en = e; x.addr = a; x.data = d;
    q.push_back(x);
  endtask

  task automatic drive(input logic [2:0] r, input logic s);
    @(negedge clk);
    req   = r;
    stall = s;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  // No grant expected at the next edge; sel/addr/data must hold the given values.
  task automatic chk_idle(input string nm, input logic [1:0] s, input logic [4:0] a,
                          input logic [31:0] d);
    @(posedge clk);
    #1;
    check({nm, "_gnt"},   64'(gnt),     64'(3'b000));
    check({nm, "_wr_en"}, 64'(wr_en),   64'(1'b0));
    check({nm, "_sel"},   64'(sel),     64'(s));
    check({nm, "_addr"},  64'(wr_addr), 64'(a));
    check({nm, "_data"},  64'(wr_data), 64'(d));
  endtask

  task automatic chk_reset(input string nm);
    check({nm, "_gnt"},   64'(gnt),     64'(3'b000));
    check({nm, "_wr_en"}, 64'(wr_en),   64'(1'b0));
    check({nm, "_sel"},   64'(sel),     64'(2'b00));
    check({nm, "_addr"},  64'(wr_addr), 64'(5'd0));
    check({nm, "_data"},  64'(wr_data), 64'(32'd0));
  endtask

  // Monitor: every grant or write must match the oldest expected entry.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (sel == 2'b11) begin
        tests++;
        fails++;
        $display("FAIL sel_illegal: got %b, expected not 11", sel);
      end
      if (gnt != 3'b000 || wr_en) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_grant: got gnt=%b wr_en=%b sel=%b addr=%0d data=%h, expected none",
                   gnt, wr_en, sel, wr_addr, wr_data);
        end else begin
          e = q.pop_front();
          if ({gnt, sel, wr_en, wr_addr, wr_data} !== e) begin
            fails++;
            $display("FAIL grant: got gnt=%b sel=%b en=%b addr=%0d data=%h, expected gnt=%b sel=%b en=%b addr=%0d data=%h",
                     gnt, sel, wr_en, wr_addr, wr_data, e.gnt, e.sel, e.en, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; req = 3'b111;
    addr_a = 5'd1; addr_b = 5'd2; addr_c = 5'd3;
    data_a = DA;   data_b = DB;   data_c = DC;

    // Reset held with all requests up.
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_reset("reset_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(3'b001, 2'b00, 1'b1, 5'd1, DA);
    push(3'b010, 2'b01, 1'b1, 5'd2, DB);
    push(3'b100, 2'b10, 1'b1, 5'd3, DC);
    drive(3'b110, 1'b0);
    drive(3'b100, 1'b0);
    drive(3'b000, 1'b0);
    chk_idle("after_abc", 2'b10, 5'd3, DC);

    // Single request from B.
    addr_b = 5'd7; data_b = 32'hDEADBEEF;
    drive(3'b010, 1'b0);
    push(3'b010, 2'b01, 1'b1, 5'd7, 32'hDEADBEEF);
    drive(3'b000, 1'b0);
    chk_idle("single_b_after", 2'b01, 5'd7, 32'hDEADBEEF);
    addr_b = 5'd2; data_b = DB;

    // Bring the pointer back to PRI_A via one C grant.
    drive(3'b100, 1'b0);
    push(3'b100, 2'b10, 1'b1, 5'd3, DC);
    drive(3'b000, 1'b0);

    // Round-robin with A and C re-requesting, then all three.
    drive(3'b101, 1'b0);
    push(3'b001, 2'b00, 1'b1, 5'd1, DA);
    push(3'b100, 2'b10, 1'b1, 5'd3, DC);
    push(3'b001, 2'b00, 1'b1, 5'd1, DA);
    push(3'b100, 2'b10, 1'b1, 5'd3, DC);
    repeat (3) drive(3'b101, 1'b0);
    drive(3'b111, 1'b0);
    push(3'b001, 2'b00, 1'b1, 5'd1, DA);
    push(3'b010, 2'b01, 1'b1, 5'd2, DB);
    push(3'b100, 2'b10, 1'b1, 5'd3, DC);
    repeat (2) drive(3'b111, 1'b0);
    drive(3'b000, 1'b0);

    // Write to $0: grant pulses, no write, request held but masked next cycle.
    addr_a = 5'd0; data_a = 32'h12345678;
    drive(3'b001, 1'b0);
    push(3'b001, 2'b00, 1'b0, 5'd0, 32'h12345678);
    drive(3'b001, 1'b0);
    chk_idle("r0_masked", 2'b00, 5'd0, 32'h12345678);
    drive(3'b000, 1'b0);
    addr_a = 5'd1; data_a = DA;

    // Stall with B and C pending; pointer is PRI_B.
    repeat (3) begin
      drive(3'b110, 1'b1);
      chk_idle("stall", 2'b00, 5'd0, 32'h12345678);
    end
    drive(3'b110, 1'b0);
    push(3'b010, 2'b01, 1'b1, 5'd2, DB);
    push(3'b100, 2'b10, 1'b1, 5'd3, DC);
    drive(3'b100, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_gnt",   64'(gnt),   64'(3'b100));
    check("pre_reset_wr_en", 64'(wr_en), 64'(1'b1));

    // Async reset mid-cycle while C's write is in flight.
    @(negedge clk);
    rst_n = 1'b0; req = 3'b000;
    #1;
    chk_reset("async_reset");

    // Leave the pointer at PRI_B, reset, then check A wins over B.
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b001, 1'b0);
    push(3'b001, 2'b00, 1'b1, 5'd1, DA);
    drive(3'b000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset2");
    @(negedge clk);
    rst_n = 1'b1;
    drive(3'b011, 1'b0);
    push(3'b001, 2'b00, 1'b1, 5'd1, DA);
    push(3'b010, 2'b01, 1'b1, 5'd2, DB);
    drive(3'b010, 1'b0);
    drive(3'b000, 1'b0);
    chk_idle("final_idle", 2'b01, 5'd2, DB);

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 64'(q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
